cast_vc_output_scheduler: RTL and testbench

Packet-aware virtual-channel scheduler for a router output port. Each cycle it selects at most one VC to drive the shared output link, holds the link for a packet's full duration (head to tail), and tracks per-VC downstream credits. No VC is granted without buffer space downstream. Its one-hot grant drives the VC data/valid mux and the per-VC pipeline-stage ready in the output arbitration stage.

---
 rtl/cast_vc_output_scheduler_if.sv | 46 ++++
 rtl/cast_vc_output_scheduler.sv | 133 +++++++++++++
 tb/tb_cast_vc_output_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cast_vc_output_scheduler_if.sv
// Output-port VC scheduler bundle: per-VC request/credit inputs and
// grant/credit/status outputs shared by the scheduler and its driver.
interface cast_vc_output_scheduler_if #(
    parameter int VN = 4,
    parameter int CW = 3
);
    logic [VN-1:0]         req_i;
    logic [VN-1:0]         head_i;
    logic [VN-1:0]         tail_i;
    logic                  out_ready_i;
    logic [VN-1:0]         credit_i;
    logic [VN-1:0]         grant_o;
    logic                  out_valid_o;
    logic                  fire_o;
    logic [VN-1:0][CW-1:0] credit_cnt_o;
    logic                  locked_o;
    logic                  err_o;

    modport master (
        output req_i,
        output head_i,
        output tail_i,
        output out_ready_i,
        output credit_i,
        input  grant_o,
        input  out_valid_o,
        input  fire_o,
        input  credit_cnt_o,
        input  locked_o,
        input  err_o
    );

    modport slave (
        input  req_i,
        input  head_i,
        input  tail_i,
        input  out_ready_i,
        input  credit_i,
        output grant_o,
        output out_valid_o,
        output fire_o,
        output credit_cnt_o,
        output locked_o,
        output err_o
    );
endinterface

// File: rtl/cast_vc_output_scheduler.sv
// Packet-aware VC scheduler for one router output port: round-robin
// head selection, packet locking head-to-tail, per-VC downstream credits.
module cast_vc_output_scheduler #(
    parameter int VN      = 4,
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    cast_vc_output_scheduler_if.slave bus
);
    localparam int IW = (VN > 1) ? $clog2(VN) : 1;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         lock_vc_q, lock_vc_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [VN-1:0][CW-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic [VN-1:0] elig;
    logic [VN-1:0] cand;
    logic [VN-1:0] grant;
    logic [IW-1:0] gidx;
    logic          found;
    logic          fire;
    logic          g_tail;

    // A VC may only be picked when it has a flit and downstream space.
    always_comb begin
        elig = '0;
        cand = '0;
        for (int v = 0; v < VN; v++) begin
            elig[v] = bus.req_i[v] && (cnt_q[v] != '0);
            cand[v] = elig[v] && bus.head_i[v];
        end
    end

    // Pick the VC for this cycle; independent of out_ready so valid holds.
    always_comb begin
        found = 1'b0;
        gidx  = lock_vc_q;
        if (state_q == S_LOCKED) begin
            found = elig[lock_vc_q];
        end else begin
            for (int i = 0; i < VN; i++) begin
                if (!found && cand[(int'(rr_ptr_q) + i) % VN]) begin
                    found = 1'b1;
                    gidx  = IW'((int'(rr_ptr_q) + i) % VN);
                end
            end
        end
        grant  = found ? ({{(VN-1){1'b0}}, 1'b1} << gidx) : '0;
        g_tail = bus.tail_i[gidx];
        fire   = found && bus.out_ready_i;
    end

    // Packet lock and round-robin pointer advance only on a transfer.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        rr_ptr_d  = rr_ptr_q;
        if (fire) begin
            case (state_q)
                S_IDLE: begin
                    if (!g_tail) begin
                        state_d   = S_LOCKED;
                        lock_vc_d = gidx;
                    end
                end
                S_LOCKED: begin
                    if (g_tail) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (g_tail) begin
                if (gidx == IW'(VN - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = gidx + 1'b1;
                end
            end
        end
    end

    // Credit bookkeeping; a return into a full counter is flagged sticky.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        for (int v = 0; v < VN; v++) begin
            if (bus.credit_i[v] && !(fire && grant[v])) begin
                if (cnt_q[v] == CW'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + 1'b1;
                end
            end else if (!bus.credit_i[v] && fire && grant[v]) begin
                cnt_d[v] = cnt_q[v] - 1'b1;
            end
        end
    end

    // State registers; reset restores full credit since downstream resets too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= {VN{CW'(CREDITS)}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.grant_o      = grant;
    assign bus.out_valid_o  = found;
    assign bus.fire_o       = fire;
    assign bus.credit_cnt_o = cnt_q;
    assign bus.locked_o     = (state_q == S_LOCKED);
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_cast_vc_output_scheduler.sv
// Directed bench for cast_vc_output_scheduler (VN=4, CREDITS=2) with a
// grant scoreboard and direct checks of credits, lock and error state.
module tb_cast_vc_output_scheduler;
    localparam int VN = 4;
    localparam int CR = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    logic       rdy_q[$];

    always #5 clk = ~clk;

    cast_vc_output_scheduler_if #(.VN(VN), .CW(CW)) bus ();

    cast_vc_output_scheduler #(
        .VN(VN),
        .CREDITS(CR),
        .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] req,
                       input logic [3:0] hd, input logic [3:0] tl,
                       input logic rdy, input logic [3:0] cr,
                       input logic [3:0] exp_g);
        logic [3:0] g;
        logic       r;
        @(posedge clk);
        #1;
        bus.req_i       = req;
        bus.head_i      = hd;
        bus.tail_i      = tl;
        bus.out_ready_i = rdy;
        bus.credit_i    = cr;
        exp_q.push_back(exp_g);
        rdy_q.push_back(rdy);
        @(negedge clk);
        g = exp_q.pop_front();
        r = rdy_q.pop_front();
        chk({tag, ".grant"}, 32'(bus.grant_o), 32'(g));
        chk({tag, ".valid"}, 32'(bus.out_valid_o), 32'(|g));
        chk({tag, ".fire"}, 32'(bus.fire_o), 32'((|g) & r));
    endtask

    task automatic chk_cnt(input string tag, input int v, input int exp);
        chk(tag, 32'(bus.credit_cnt_o[v]), 32'(exp));
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_i       = '0;
        bus.head_i      = '0;
        bus.tail_i      = '0;
        bus.out_ready_i = 1'b1;
        bus.credit_i    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.grant", 32'(bus.grant_o), 32'h0);
        chk("rst.valid", 32'(bus.out_valid_o), 32'h0);
        chk("rst.fire", 32'(bus.fire_o), 32'h0);
        chk("rst.locked", 32'(bus.locked_o), 32'h0);
        chk("rst.err", 32'(bus.err_o), 32'h0);
        for (int v = 0; v < VN; v++) chk_cnt("rst.cnt", v, CR);

        // single-flit packets from VC1 and VC3, round robin
        cyc("t1a", 4'b1010, 4'b1010, 4'b1010, 1'b1, 4'b0000, 4'b0010);
        cyc("t1b", 4'b1010, 4'b1010, 4'b1010, 1'b1, 4'b0000, 4'b1000);
        cyc("t1c", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1010, 4'b0000);
        chk_cnt("t1.cnt0", 0, 2);
        chk_cnt("t1.cnt1", 1, 1);
        chk_cnt("t1.cnt3", 3, 1);
        chk("t1.locked", 32'(bus.locked_o), 32'h0);
        cyc("t1d", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        chk_cnt("t1.cnt1r", 1, 2);
        chk_cnt("t1.cnt3r", 3, 2);

        // 3-flit packet on VC0 with VC2 heads competing
        cyc("t2a", 4'b0101, 4'b0101, 4'b0000, 1'b1, 4'b0000, 4'b0001);
        cyc("t2b", 4'b0101, 4'b0100, 4'b0000, 1'b1, 4'b0001, 4'b0001);
        chk("t2.lockb", 32'(bus.locked_o), 32'h1);
        cyc("t2c", 4'b0101, 4'b0100, 4'b0001, 1'b1, 4'b0001, 4'b0001);
        chk("t2.lockc", 32'(bus.locked_o), 32'h1);
        cyc("t2d", 4'b0100, 4'b0100, 4'b0100, 1'b1, 4'b0000, 4'b0100);
        chk("t2.unlock", 32'(bus.locked_o), 32'h0);
        chk_cnt("t2.cnt0", 0, 1);
        cyc("t2e", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0101, 4'b0000);
        chk_cnt("t2.cnt2", 2, 1);
        // stall: grant held, nothing transfers
        cyc("stall", 4'b0010, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010);
        chk_cnt("t4.dual0", 0, 2);
        chk_cnt("t4.dual2", 2, 2);
        cyc("stall2", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        chk("stall.locked", 32'(bus.locked_o), 32'h0);
        chk_cnt("stall.cnt1", 1, 2);

        // credit exhaustion on VC0 while locked
        cyc("t3a", 4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0000, 4'b0001);
        cyc("t3b", 4'b0011, 4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0001);
        cyc("t3c", 4'b0011, 4'b0010, 4'b0001, 1'b1, 4'b0001, 4'b0000);
        chk_cnt("t3.cnt0", 0, 0);
        chk("t3.locked", 32'(bus.locked_o), 32'h1);
        cyc("t3d", 4'b0011, 4'b0010, 4'b0001, 1'b1, 4'b0000, 4'b0001);
        cyc("t3e", 4'b0010, 4'b0010, 4'b0010, 1'b1, 4'b0000, 4'b0010);
        chk("t3.unlock", 32'(bus.locked_o), 32'h0);
        chk_cnt("t3.cnt0z", 0, 0);

        // fire and credit return together on VC1 with cnt=1
        cyc("t4a", 4'b0010, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010);
        chk_cnt("t4.cnt1", 1, 1);
        cyc("t4b", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0011, 4'b0000);
        chk_cnt("t4.same", 1, 1);
        cyc("t4c", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000);
        chk_cnt("t4.inc0", 0, 1);
        chk_cnt("t4.inc1", 1, 2);
        chk("t4.err", 32'(bus.err_o), 32'h0);

        // overflow on VC2
        cyc("t5a", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0000);
        chk_cnt("t5.cnt0", 0, 2);
        cyc("t5b", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        chk_cnt("t5.cnt2", 2, 2);
        chk("t5.err", 32'(bus.err_o), 32'h1);
        cyc("t5c", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        chk("t5.sticky", 32'(bus.err_o), 32'h1);

        // reset mid-packet on VC3 with credits drained
        cyc("t6a", 4'b1000, 4'b1000, 4'b0000, 1'b1, 4'b0000, 4'b1000);
        cyc("t6b", 4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1000);
        chk("t6.locked", 32'(bus.locked_o), 32'h1);
        @(posedge clk);
        #1;
        chk_cnt("t6.cnt3", 3, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_i = '0;
        @(negedge clk);
        chk("t6.unlock", 32'(bus.locked_o), 32'h0);
        chk("t6.err", 32'(bus.err_o), 32'h0);
        for (int v = 0; v < VN; v++) chk_cnt("t6.cnt", v, CR);
        cyc("t6c", 4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);
        cyc("t6d", 4'b1001, 4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
